// File: rtl/opcodes.sv
// Shared datapath opcode definitions: multiply/divide operation select and
// bit positions within the muldiv flag vector.
package opcodes;

  typedef enum logic [1:0] {
    MdMul  = 2'd0,
    MdMulH = 2'd1,
    MdDiv  = 2'd2,
    MdRem  = 2'd3
  } muldiv_op_t;

  localparam int FlagZ = 3;
  localparam int FlagN = 2;
  localparam int FlagV = 1;
  localparam int FlagD = 0;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: one result bit per cycle, with a
// single shared adder for accumulate, restoring subtract and sign negation.
module muldiv_unit
  import opcodes::*;
#(
  parameter int  WIDTH = 16,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  muldiv_op_t       MdOp,
  input  logic             Signed,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             Abort,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Flags
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIN} state_t;

  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nx;
  muldiv_op_t       op;
  logic             sgn, neg, div0, dovf;
  logic [WIDTH-1:0] acc, lo, b_reg;
  logic [CW-1:0]    cnt;

  logic             accept, is_mul;
  logic [WIDTH:0]   add_a, add_b, add_s, shifted, mul_t;
  logic             add_ci, add_co;
  logic [WIDTH-1:0] fin_raw, res_nx;
  logic             fin_ci, mul_v;
  logic [3:0]       flg_nx;

  assign accept  = Start && (state == S_IDLE || state == S_FIN);
  assign is_mul  = (op == MdMul) || (op == MdMulH);
  assign shifted = {acc, lo[WIDTH-1]};

  // FSM: state register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // FSM: next state; Abort beats the CALC->FIN transition
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (Start) state_nx = S_PREP;
      S_PREP:  state_nx = Abort ? S_IDLE : S_CALC;
      S_CALC:  if (Abort) state_nx = S_IDLE;
               else if (cnt == LAST) state_nx = S_FIN;
      S_FIN:   state_nx = Start ? S_PREP : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    Busy = (state != S_IDLE);
  end

  // FIN negation of the high product half borrows from the low half:
  // -{hi,lo} has high half ~hi + (lo == 0).
  assign fin_raw = (op == MdMulH || op == MdRem) ? acc : lo;
  assign fin_ci  = (op == MdMulH) ? (lo == '0) : 1'b1;

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    case (state)
      S_PREP: begin
        add_a  = {1'b0, ~lo};
        add_ci = 1'b1;
      end
      S_CALC: begin
        if (is_mul) begin
          add_a = {1'b0, acc};
          add_b = {1'b0, b_reg};
        end else begin
          add_a  = shifted;
          add_b  = ~{1'b0, b_reg};
          add_ci = 1'b1;
        end
      end
      S_FIN: begin
        add_a  = {1'b0, ~fin_raw};
        add_ci = fin_ci;
      end
      default: ;
    endcase
  end

  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_ci};
  assign mul_t           = lo[0] ? add_s : {1'b0, acc};

  // Signed product fits in WIDTH bits iff magnitude <= MAX, or == MIN when negative.
  always_comb begin
    res_nx = neg ? add_s[WIDTH-1:0] : fin_raw;
    mul_v  = sgn ? !(acc == '0 && (!lo[WIDTH-1] || (neg && lo[WIDTH-2:0] == '0)))
                 : (acc != '0);
    flg_nx = '0;
    case (op)
      MdMul:  flg_nx[FlagV] = mul_v;
      MdMulH: ;
      MdDiv: begin
        if (div0)      res_nx = '1;
        else if (dovf) res_nx = MIN_VAL;
        flg_nx[FlagV] = dovf;
        flg_nx[FlagD] = div0;
      end
      MdRem: begin
        if (dovf) res_nx = '0;
        flg_nx[FlagV] = dovf;
        flg_nx[FlagD] = div0;
      end
      default: ;
    endcase
    flg_nx[FlagZ] = (res_nx == '0);
    flg_nx[FlagN] = res_nx[WIDTH-1];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op     <= MdMul;
      sgn    <= 1'b0;
      neg    <= 1'b0;
      div0   <= 1'b0;
      dovf   <= 1'b0;
      acc    <= '0;
      lo     <= '0;
      b_reg  <= '0;
      cnt    <= '0;
      Done   <= 1'b0;
      Result <= '0;
      Flags  <= '0;
    end else begin
      Done <= (state == S_FIN);
      if (state == S_FIN) begin
        Result <= res_nx;
        Flags  <= flg_nx;
      end
      if (accept) begin
        op    <= MdOp;
        sgn   <= Signed;
        lo    <= OpA;
        b_reg <= OpB;
      end
      case (state)
        S_PREP: begin
          acc  <= '0;
          cnt  <= '0;
          if (sgn && lo[WIDTH-1])    lo    <= add_s[WIDTH-1:0];
          if (sgn && b_reg[WIDTH-1]) b_reg <= -b_reg;
          neg  <= sgn && (op == MdRem ? lo[WIDTH-1] : (lo[WIDTH-1] ^ b_reg[WIDTH-1]));
          div0 <= (b_reg == '0);
          dovf <= sgn && (lo == MIN_VAL) && (b_reg == '1);
        end
        S_CALC: begin
          cnt <= cnt + CW'(1);
          if (is_mul) begin
            acc <= mul_t[WIDTH:1];
            lo  <= {mul_t[0], lo[WIDTH-1:1]};
          end else begin
            // Remainder after a step is always below the divisor, so WIDTH bits hold it.
            acc <= add_co ? add_s[WIDTH-1:0] : shifted[WIDTH-1:0];
            lo  <= {lo[WIDTH-2:0], add_co};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH=16) with hand-computed results.
module tb_muldiv_unit;
  import opcodes::*;

  logic        clk = 1'b0;
  logic        rst, start, sgn, abort;
  muldiv_op_t  md_op;
  logic [15:0] op_a, op_b, res;
  logic        busy, done;
  logic [3:0]  flags;

  int n_chk = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(16)) dut (
    .Clock(clk), .Reset(rst), .Start(start), .MdOp(md_op), .Signed(sgn),
    .OpA(op_a), .OpB(op_b), .Abort(abort), .Busy(busy), .Done(done),
    .Result(res), .Flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns cycles from entry until Done is seen, or 0 if the bound expires.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input muldiv_op_t op, input logic sg,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic [3:0] ef);
    int cyc;
    @(negedge clk);
    md_op = op; sgn = sg; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk({tag, " lat"}, cyc, 18);
    chk({tag, " res"}, {16'h0, res}, {16'h0, er});
    chk({tag, " flg"}, {28'h0, flags}, {28'h0, ef});
    chk({tag, " busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int  cyc;
    logic saw;
    rst = 1'b1; start = 1'b0; abort = 1'b0; sgn = 1'b0; md_op = MdMul;
    op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst done", {31'h0, done}, 32'h0);
    chk("rst res", {16'h0, res}, 32'h0);
    chk("rst flg", {28'h0, flags}, 32'h0);
    rst = 1'b0;

    //       tag          op      sg    a         b         result    {Z,N,V,D}
    run_op("mul 300*200", MdMul,  1'b0, 16'd300,  16'd200,  16'hEA60, 4'b0100);
    run_op("mul -3*5",    MdMul,  1'b1, 16'hFFFD, 16'd5,    16'hFFF1, 4'b0100);
    run_op("mulh -3*5",   MdMulH, 1'b1, 16'hFFFD, 16'd5,    16'hFFFF, 4'b0100);
    run_op("mul 256^2",   MdMul,  1'b0, 16'h0100, 16'h0100, 16'h0000, 4'b1010);
    run_op("mul s ovf",   MdMul,  1'b1, 16'h4000, 16'd2,    16'h8000, 4'b0110);
    run_op("mul s min",   MdMul,  1'b1, 16'hC000, 16'd2,    16'h8000, 4'b0100);
    run_op("mulh u max",  MdMulH, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 4'b0100);
    run_op("div -7/2",    MdDiv,  1'b1, 16'hFFF9, 16'd2,    16'hFFFD, 4'b0100);
    run_op("rem -7/2",    MdRem,  1'b1, 16'hFFF9, 16'd2,    16'hFFFF, 4'b0100);
    run_op("rem 7/-2",    MdRem,  1'b1, 16'd7,    16'hFFFE, 16'h0001, 4'b0000);
    run_op("div u fff9",  MdDiv,  1'b0, 16'hFFF9, 16'd2,    16'h7FFC, 4'b0000);
    run_op("div by 0",    MdDiv,  1'b0, 16'd1234, 16'd0,    16'hFFFF, 4'b0101);
    run_op("rem by 0",    MdRem,  1'b0, 16'd1234, 16'd0,    16'h04D2, 4'b0001);
    run_op("rem s by 0",  MdRem,  1'b1, 16'hFFFB, 16'd0,    16'hFFFB, 4'b0101);
    run_op("div min/-1",  MdDiv,  1'b1, 16'h8000, 16'hFFFF, 16'h8000, 4'b0110);
    run_op("rem min/-1",  MdRem,  1'b1, 16'h8000, 16'hFFFF, 16'h0000, 4'b1010);

    // Back-to-back: Start held across the first Done cycle
    @(negedge clk);
    md_op = MdMul; sgn = 1'b0; op_a = 16'd300; op_b = 16'd200; start = 1'b1;
    @(posedge clk); @(negedge clk);
    md_op = MdDiv; op_a = 16'hFFF9; op_b = 16'd2;
    wait_done(cyc);
    start = 1'b0;
    chk("b2b lat1", cyc, 18);
    chk("b2b res1", {16'h0, res}, 32'hEA60);
    chk("b2b busy", {31'h0, busy}, 32'h1);
    wait_done(cyc);
    chk("b2b lat2", cyc, 18);
    chk("b2b res2", {16'h0, res}, 32'h7FFC);
    chk("b2b busy2", {31'h0, busy}, 32'h0);

    // Start pulse mid-CALC is ignored
    @(negedge clk);
    md_op = MdMul; sgn = 1'b0; op_a = 16'd300; op_b = 16'd200; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (7) begin @(posedge clk); @(negedge clk); end
    md_op = MdDiv; op_a = 16'd5; op_b = 16'd5; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk("midstart lat", cyc, 10);
    chk("midstart res", {16'h0, res}, 32'hEA60);
    @(posedge clk); @(negedge clk);
    chk("midstart idle", {31'h0, busy}, 32'h0);

    // Abort at CALC cycle 5
    md_op = MdMul; op_a = 16'h1234; op_b = 16'd3; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (5) begin @(posedge clk); @(negedge clk); end
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    chk("abort busy", {31'h0, busy}, 32'h0);
    saw = 1'b0;
    repeat (25) begin @(posedge clk); @(negedge clk); saw = saw | done; end
    chk("abort nodone", {31'h0, saw}, 32'h0);
    chk("abort res", {16'h0, res}, 32'hEA60);
    chk("abort flg", {28'h0, flags}, 32'h4);

    // Asynchronous reset mid-CALC
    md_op = MdMul; sgn = 1'b1; op_a = 16'h4000; op_b = 16'd2; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (6) begin @(posedge clk); @(negedge clk); end
    #1 rst = 1'b1;
    #1;
    chk("arst busy", {31'h0, busy}, 32'h0);
    chk("arst done", {31'h0, done}, 32'h0);
    chk("arst res", {16'h0, res}, 32'h0);
    chk("arst flg", {28'h0, flags}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post rst div", MdDiv, 1'b1, 16'hFFF9, 16'd2, 16'hFFFD, 4'b0100);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit that sits beside the combinational ALU in the processor datapath. It accepts two WIDTH-bit operands and an operation under a Start/Busy/Done handshake and computes one result bit per cycle (radix-2 shift-add / restoring divide). The result and a 4-bit flag vector are registered and held until the next accepted operation. The control unit stalls on Busy and routes Result onto the register write-data path.

## Interface

- WIDTH, 16: operand and result width in bits; must be at least 4.
- CW, $clog2(WIDTH+1): iteration counter width; derived, not overridden.

- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high; clears all state.
- Start  in  1  request; accepted only on an edge where the unit is in IDLE or FIN.
- MdOp  in  2  opcodes::muldiv_op_t: MdMul (low half of product), MdMulH (high half), MdDiv (quotient), MdRem (remainder).
- Signed  in  1  1 selects two's-complement operands; 0 selects unsigned.
- OpA, OpB  in  WIDTH  multiplicand/dividend, multiplier/divisor; sampled only on the accepting edge.
- Abort  in  1  cancels an operation in PREP or CALC.
- Busy  out  1  high in PREP, CALC and FIN.
- Done  out  1  registered one-cycle pulse; Result and Flags are valid from that cycle.
- Result  out  WIDTH  registered result.
- Flags  out  4  registered {Z, N, V, D}:
  - Z: Result is zero.
  - N: Result MSB.
  - V: overflow.
  - D: divide by zero.

## Operation

- States are IDLE, PREP, CALC and FIN.
- IDLE: Busy=0. With Start=1, the edge latches MdOp, Signed, OpA and OpB and moves to PREP.
- PREP, one cycle:
  - When Signed=1, store the absolute values and the result sign. For MUL/MULH the sign is the XOR of the operand signs. For REM it is the sign of OpA.
  - Detect the special cases: divisor zero, and signed MIN / -1.
  - Clear the counter. Move to CALC.
- CALC, exactly WIDTH cycles:
  - MUL/MULH: shift-add into a 2*WIDTH-bit product register.
  - DIV/REM: restoring shift-subtract into a WIDTH+1-bit partial remainder and a WIDTH-bit quotient.
  - The counter increments each edge. On the edge where the counter reaches WIDTH-1, move to FIN.
- FIN:
  - Apply the sign correction (two's-complement negate) and select the result half.
  - On the next edge, register Result and Flags, pulse Done and move to IDLE.
  - If Start=1 on that same edge, latch the new operands and go to PREP instead; back-to-back operation is allowed.
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Flag V:
  - MUL (Signed=1): set when the full product is not the sign-extension of its low half.
  - MUL (Signed=0): set when the high half is nonzero.
  - MULH: always 0.
  - DIV/REM: set for signed MIN / -1, which forces quotient MIN and remainder 0.
- Divide by zero: quotient is all-ones, remainder is OpA unchanged, D=1, V=0. The operation still takes the full latency.
- Start while in PREP or CALC: ignored, with no effect.
- Abort in PREP or CALC: the next edge returns to IDLE. No Done is produced; Result and Flags keep their previous values. Abort has priority over the CALC→FIN transition. Abort in IDLE or FIN is ignored.
- Reset, asynchronous and at any time including mid-operation:
  - State goes to IDLE.
  - Busy=0, Done=0, Result=0, Flags=4'b0000.
  - Internal registers and the counter are cleared.

## Timing

- Accepting edge is t0. The unit is in PREP after t0 and in CALC from t0+1 to t0+WIDTH+1. It is in FIN after edge t0+WIDTH+1.
- Done=1 and the new Result are visible after edge t0+WIDTH+2, for one cycle. Latency is WIDTH+2 cycles; for WIDTH=16 that is 18.
- Busy is high from t0 until edge t0+WIDTH+2. Busy is low during the Done cycle.
- Maximum throughput is one operation per WIDTH+2 cycles when Start is held high.
- Result and Flags are stable at all times other than the Done-producing edge.

## Structure

- The opcodes package gains muldiv_op_t (2-bit enum: MdMul=0, MdMulH=1, MdDiv=2, MdRem=3).
- The opcodes package also gains the flag index constants FlagZ=3, FlagN=2, FlagV=1, FlagD=0.
- The state enum is local to the module.
- No sub-module: one FSM plus the shared shift registers and one WIDTH+1-bit adder/subtractor, used for the product accumulate, the remainder subtract and the sign negate.

## Test plan

All scenarios use WIDTH=16.

- MdMul, Signed=0, 300*200 -> Done exactly 18 cycles after accept; Result=0xEA60, Flags Z=0 N=1 V=0 D=0.
- Signed=1, -3*5: MdMul -> 0xFFF1 with V=0; MdMulH -> 0xFFFF. Unsigned 0x0100*0x0100 MdMul -> 0x0000 with Z=1, V=1.
- Signed=1, -7/2: MdDiv -> 0xFFFD; MdRem -> 0xFFFF. Signed=0, 0xFFF9/2: MdDiv -> 0x7FFC.
- 1234/0: MdDiv -> 0xFFFF with D=1; MdRem -> 0x04D2 with D=1. Signed 0x8000/0xFFFF: MdDiv -> 0x8000 with V=1; MdRem -> 0x0000 with V=1.
- Back-to-back: Start held high across the Done cycle -> second Done exactly 18 cycles after the first. A Start pulse mid-CALC -> ignored.
- Abort at CALC cycle 5 -> Busy low next cycle, no Done, Result unchanged. Reset asserted mid-CALC -> Busy=0, Result=0, Flags=0 immediately.
